// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU: accept, execute, respond.
// One operation in flight at a time; the result is steered back to the requesting port.
module alu_arbiter #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [3:0]  r0_ctrl,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  output logic        r0_done,
  output logic [31:0] r0_result,
  output logic        r0_zero,
  output logic        r0_err,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [3:0]  r1_ctrl,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  output logic        r1_done,
  output logic [31:0] r1_result,
  output logic        r1_zero,
  output logic        r1_err,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1011;

  state_t      state, state_nxt;
  logic        last_grant, grant, accept, lat_port;
  logic [3:0]  lat_ctrl;
  logic [31:0] lat_a, lat_b, res_result;
  logic        res_zero, res_err, legal, resp;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    accept    = 1'b0;
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    case (state)
      IDLE: begin
        // on a tie, round-robin hands the grant to the port not served last
        if (r0_valid && r1_valid)
          grant = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
        else
          grant = r1_valid;
        accept   = (r0_valid || r1_valid) && !reset;
        r0_ready = accept && !grant;
        r1_ready = accept && grant;
        if (accept) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (lat_ctrl)
      OP_ADD, OP_SLL, OP_AND, OP_NOR, OP_BEQ, OP_SLT: legal = 1'b1;
      default:                                        legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_port   <= 1'b0;
      lat_ctrl   <= 4'd0;
      lat_a      <= 32'd0;
      lat_b      <= 32'd0;
      res_result <= 32'd0;
      res_zero   <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant;
        lat_port   <= grant;
        lat_ctrl   <= grant ? r1_ctrl : r0_ctrl;
        lat_a      <= grant ? r1_a : r0_a;
        lat_b      <= grant ? r1_b : r0_b;
      end
      // beq reports only the flag; illegal opcodes report only err
      if (state == EXEC) begin
        res_result <= (legal && lat_ctrl != OP_BEQ) ? alu_out : 32'd0;
        res_zero   <= legal && lat_ctrl == OP_BEQ && alu_zero;
        res_err    <= !legal;
      end
    end
  end

  assign alu_in1  = lat_a;
  assign alu_in2  = lat_b;
  assign alu_ctrl = lat_ctrl;
  assign busy     = state != IDLE;
  assign resp     = state == RESP;

  assign r0_done   = resp && !lat_port;
  assign r1_done   = resp && lat_port;
  assign r0_result = r0_done ? res_result : 32'd0;
  assign r1_result = r1_done ? res_result : 32'd0;
  assign r0_zero   = r0_done && res_zero;
  assign r1_zero   = r1_done && res_zero;
  assign r0_err    = r0_done && res_err;
  assign r1_err    = r1_done && res_err;

endmodule
